// File: rtl/pwm_led_array.sv
// Multi-channel PWM LED driver with shadowed duty registers loaded at period boundaries.
// Optional PWM_FADE_EN adds fade_mask: masked channels ramp one LSB per period toward their shadow duty.
module pwm_led_array #(
    parameter int CH      = 4,
    parameter int PWM_W   = 8,
    parameter int PRESC_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [PRESC_W-1:0] presc,
    input  logic               duty_wr,
    input  logic [3:0]         duty_ch,
    input  logic [PWM_W-1:0]   duty_data,
`ifdef PWM_FADE_EN
    input  logic [CH-1:0]      fade_mask,
`endif
    output logic [CH-1:0]      led,
    output logic               period_tick
);

    localparam logic [PWM_W-1:0]   CNT_MAX   = {PWM_W{1'b1}};
    localparam logic [PWM_W-1:0]   PWM_ONE   = {{(PWM_W-1){1'b0}}, 1'b1};
    localparam logic [PRESC_W-1:0] PRESC_ONE = {{(PRESC_W-1){1'b0}}, 1'b1};

    logic [PRESC_W-1:0] presc_cnt_r;
    logic [PWM_W-1:0]   pwm_cnt_r;
    logic [PWM_W-1:0]   shadow_r      [CH];
    logic [PWM_W-1:0]   active_r      [CH];
    logic [PWM_W-1:0]   shadow_next_s [CH];
    logic [PWM_W-1:0]   active_next_s [CH];
    logic               tick_s;
    logic               wrap_s;

`ifdef PWM_FADE_EN
    function automatic logic [PWM_W-1:0] step_toward(input logic [PWM_W-1:0] cur,
                                                     input logic [PWM_W-1:0] tgt);
        if (cur < tgt) begin
            return cur + PWM_ONE;
        end else if (cur > tgt) begin
            return cur - PWM_ONE;
        end else begin
            return cur;
        end
    endfunction
`endif

    // Prescaler compare and period-boundary detection; >= keeps a lowered presc from skipping a tick.
    always_comb begin
        tick_s = enable && (presc_cnt_r >= presc);
        wrap_s = tick_s && (pwm_cnt_r == CNT_MAX);
    end

    // Shadow update; an out-of-range channel index matches no slot and is dropped.
    always_comb begin
        for (int i = 0; i < CH; i++) begin
            if (duty_wr && (duty_ch == 4'(i))) begin
                shadow_next_s[i] = duty_data;
            end else begin
                shadow_next_s[i] = shadow_r[i];
            end
        end
    end

    // Active duty: tracks shadow while disabled, otherwise loads (or ramps) only on wrap.
    always_comb begin
        for (int i = 0; i < CH; i++) begin
            if (!enable) begin
                active_next_s[i] = shadow_next_s[i];
            end else if (wrap_s) begin
`ifdef PWM_FADE_EN
                if (fade_mask[i]) begin
                    active_next_s[i] = step_toward(active_r[i], shadow_next_s[i]);
                end else begin
                    active_next_s[i] = shadow_next_s[i];
                end
`else
                active_next_s[i] = shadow_next_s[i];
`endif
            end else begin
                active_next_s[i] = active_r[i];
            end
        end
    end

    // Counters, duty registers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_cnt_r <= {PRESC_W{1'b0}};
            pwm_cnt_r   <= {PWM_W{1'b0}};
            led         <= {CH{1'b0}};
            period_tick <= 1'b0;
            for (int i = 0; i < CH; i++) begin
                shadow_r[i] <= {PWM_W{1'b0}};
                active_r[i] <= {PWM_W{1'b0}};
            end
        end else begin
            if (!enable) begin
                presc_cnt_r <= {PRESC_W{1'b0}};
                pwm_cnt_r   <= {PWM_W{1'b0}};
            end else if (tick_s) begin
                presc_cnt_r <= {PRESC_W{1'b0}};
                pwm_cnt_r   <= pwm_cnt_r + PWM_ONE;
            end else begin
                presc_cnt_r <= presc_cnt_r + PRESC_ONE;
            end
            period_tick <= wrap_s;
            for (int i = 0; i < CH; i++) begin
                led[i]      <= enable && (pwm_cnt_r < active_r[i]);
                shadow_r[i] <= shadow_next_s[i];
                active_r[i] <= active_next_s[i];
            end
        end
    end

endmodule

// File: tb/tb_pwm_led_array.sv
// Randomised bench for pwm_led_array against a per-clock behavioural model,
// plus directed duty-count measurements over whole PWM periods.
module tb_pwm_led_array;

    localparam int CH     = 4;
    localparam int PERIOD = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [7:0]    presc;
    logic          duty_wr;
    logic [3:0]    duty_ch;
    logic [7:0]    duty_data;
    logic [CH-1:0] led;
    logic          period_tick;
`ifdef PWM_FADE_EN
    logic [CH-1:0] fade_mask = '0;
`endif

    pwm_led_array #(.CH(CH), .PWM_W(8), .PRESC_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .presc       (presc),
        .duty_wr     (duty_wr),
        .duty_ch     (duty_ch),
        .duty_data   (duty_data),
`ifdef PWM_FADE_EN
        .fade_mask   (fade_mask),
`endif
        .led         (led),
        .period_tick (period_tick)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: prescale position, PWM position, duties as plain integers.
    int            m_pc;
    int            m_cnt;
    int            m_sh  [CH];
    int            m_act [CH];
    logic [CH-1:0] m_led;
    logic          m_pt;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc  = 0;
        m_cnt = 0;
        m_led = '0;
        m_pt  = 1'b0;
        for (int i = 0; i < CH; i++) begin
            m_sh[i]  = 0;
            m_act[i] = 0;
        end
    endtask

    // One clock of the reference behaviour, from the input values present at the edge.
    task automatic model_step();
        int  nsh [CH];
        bit  tick;
        bit  wrap;
        nsh = m_sh;
        if (duty_wr && (int'(duty_ch) < CH)) nsh[duty_ch] = int'(duty_data);
        if (enable) begin
            tick = (m_pc >= int'(presc));
            wrap = tick && (m_cnt == PERIOD - 1);
            for (int i = 0; i < CH; i++) m_led[i] = (m_cnt < m_act[i]);
            m_pc = tick ? 0 : m_pc + 1;
            if (tick) m_cnt = (m_cnt + 1) % PERIOD;
            if (wrap) m_act = nsh;
            m_pt = wrap;
        end else begin
            m_pc  = 0;
            m_cnt = 0;
            m_led = '0;
            m_act = nsh;
            m_pt  = 1'b0;
        end
        m_sh = nsh;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_val("led", 32'(led), 32'(m_led));
        check_val("period_tick", 32'(period_tick), 32'(m_pt));
    endtask

    task automatic write_duty(input int ch, input int data);
        duty_wr   = 1'b1;
        duty_ch   = 4'(ch);
        duty_data = 8'(data);
        cycle();
        duty_wr   = 1'b0;
    endtask

    task automatic wait_pt(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            cycle();
            seen = period_tick;
        end
        check_val("period_tick_timeout", 32'(seen), 32'd1);
    endtask

    int hi;
    int pts;

    initial begin
        rst = 1'b1; enable = 1'b0; presc = 8'd0;
        duty_wr = 1'b0; duty_ch = 4'd0; duty_data = 8'd0;
        model_reset();
        #12;
        check_val("reset_led", 32'(led), 32'd0);
        check_val("reset_period_tick", 32'(period_tick), 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // ch0 = 64 at full tick rate: 64 of 256 clocks high, one period_tick per 256.
        enable = 1'b1;
        write_duty(0, 64);
        wait_pt(600);
        hi = 0; pts = 0;
        repeat (256) begin cycle(); hi += int'(led[0]); pts += int'(period_tick); end
        check_val("ch0_64_high", 32'(hi), 32'd64);
        check_val("ch0_period_ticks", 32'(pts), 32'd1);

        // presc = 3, ch1 = 128: 1024-clock period, 512 high clocks.
        presc = 8'd3;
        write_duty(1, 128);
        write_duty(3, 255);
        write_duty(7, 99);
        wait_pt(2500);
        wait_pt(1100);
        hi = 0; pts = 0;
        repeat (1024) begin
            cycle();
            hi  += int'(led[1]);
            pts += int'(!led[3]);
        end
        check_val("ch1_128_high", 32'(hi), 32'd512);
        check_val("ch3_255_low_clks", 32'(pts), 32'd4);

        // Disable drops LEDs next clock; a write while disabled shows in the first period.
        enable = 1'b0;
        cycle();
        check_val("disable_led", 32'(led), 32'd0);
        presc = 8'd0;
        write_duty(0, 32);
        enable = 1'b1;
        hi = 0;
        repeat (256) begin cycle(); hi += int'(led[0]); end
        check_val("reenable_ch0_32", 32'(hi), 32'd32);

        // Asynchronous reset in mid-period.
        repeat (10) cycle();
        rst = 1'b1;
        #1;
        check_val("async_rst_led", 32'(led), 32'd0);
        check_val("async_rst_pt", 32'(period_tick), 32'd0);
        model_reset();
        @(posedge clk); #1 rst = 1'b0;

        // Random traffic: writes (in/out of range, boundary values), presc changes, enable toggles.
        repeat (15000) begin
            if ($urandom_range(0, 199) == 0) presc = 8'($urandom_range(0, 3));
            if ($urandom_range(0, 299) == 0) enable = ~enable;
            duty_wr = ($urandom_range(0, 19) == 0);
            duty_ch = 4'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0:       duty_data = 8'd0;
                1:       duty_data = 8'd255;
                default: duty_data = 8'($urandom_range(0, 255));
            endcase
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
